// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, reads a zero-latency instruction memory
// and queues {pc, instr} pairs for decode behind a valid/ready handshake.
module fetch_unit #(
  parameter int                   WORD_SIZE    = 32,
  parameter logic [WORD_SIZE-1:0] BOOT_PC      = '0,
  parameter int                   DEPTH        = 2,
  parameter bit                   HALT_ON_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [WORD_SIZE-1:0] imem_pc,
  input  logic [WORD_SIZE-1:0] imem_instr,
  output logic                 dec_valid,
  input  logic                 dec_ready,
  output logic [WORD_SIZE-1:0] dec_pc,
  output logic [WORD_SIZE-1:0] dec_instr,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 halted_q, halted_d;
  logic [WORD_SIZE-1:0] pc_mem_q    [DEPTH];
  logic [WORD_SIZE-1:0] instr_mem_q [DEPTH];

  logic fire;
  logic push;
  logic pop;
  logic zero_hit;

  assign imem_pc   = pc_q;
  assign halted    = halted_q;
  assign dec_valid = (count_q != '0);
  assign dec_pc    = dec_valid ? pc_mem_q[head_q]    : '0;
  assign dec_instr = dec_valid ? instr_mem_q[head_q] : '0;

  // Redirect wins over everything: it flushes the queue, so any pop in that cycle is moot.
  always_comb begin
    fire     = !rst && !redirect_valid && !halted_q && (count_q < DEPTH_C);
    push     = fire;
    pop      = dec_valid && dec_ready;
    zero_hit = HALT_ON_ZERO && (imem_instr == '0);

    pc_d     = pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    halted_d = halted_q;

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      halted_d = 1'b0;
    end else begin
      if (push) begin
        tail_d = tail_q + PW'(1);
        if (zero_hit) begin
          halted_d = 1'b1;
        end else begin
          pc_d = pc_q + WORD_SIZE'(1);
        end
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= BOOT_PC;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[tail_q]    <= pc_q;
      instr_mem_q[tail_q] <= imem_instr;
    end
  end

endmodule
